// File: rtl/and_asr_add_unit.sv
// Logic/shift/add lane of the MiniMicro ALU: AND, arithmetic shift right, ADD and ADC.
// Result and NZCV flags are registered one cycle after the operands are sampled.
module and_asr_add_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [4:0]  OP_ANDS = 5'd1,
  parameter logic [4:0]  OP_ADCS = 5'd5,
  parameter logic [4:0]  OP_ADDS = 5'd6,
  parameter logic [4:0]  OP_ASR  = 5'd12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       instruction,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  logic [WIDTH-1:0] result_nxt;
  logic [3:0]       flags_nxt;
  logic [SUM_W-1:0] sum_ext;
  logic             carry_in;
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] asr_val;

  // ADCS consumes the C flag held from the previous operation
  assign carry_in = (instruction == OP_ADCS) ? flags[2] : 1'b0;
  assign sum_ext  = SUM_W'(num1) + SUM_W'(num2) + SUM_W'(carry_in);
  assign sh_amt   = num2[4:0];
  assign asr_val  = WIDTH'($signed(num1) >>> sh_amt);

  // Next result and flags; flags are {V, C, Z, N}
  always_comb begin
    result_nxt = '0;
    flags_nxt  = flags;
    unique case (instruction)
      OP_ANDS: begin
        result_nxt   = num1 & num2;
        flags_nxt[0] = result_nxt[MSB];
        flags_nxt[1] = (result_nxt == '0);
        flags_nxt[2] = 1'b0;
      end
      OP_ADDS, OP_ADCS: begin
        result_nxt   = sum_ext[WIDTH-1:0];
        flags_nxt[0] = result_nxt[MSB];
        flags_nxt[1] = (result_nxt == '0);
        flags_nxt[2] = sum_ext[WIDTH];
        flags_nxt[3] = (num1[MSB] == num2[MSB]) && (result_nxt[MSB] != num1[MSB]);
      end
      OP_ASR: begin
        result_nxt   = asr_val;
        flags_nxt[0] = result_nxt[MSB];
        flags_nxt[1] = (result_nxt == '0);
        // Zero shift moves nothing out, so C is left untouched
        if (sh_amt != 5'd0) begin
          flags_nxt[2] = num1[sh_amt - 5'd1];
        end
      end
      default: begin
        result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      result <= result_nxt;
      flags  <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_and_asr_add_unit.sv
// Self-checking bench for and_asr_add_unit: directed plan cases plus randomized
// traffic compared against an arithmetic reference model of the flags and result.
module tb_and_asr_add_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  instruction;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] result;
  logic [3:0]  flags;

  logic [31:0] m_result;
  logic [3:0]  m_flags;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  and_asr_add_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .instruction(instruction),
    .num1(num1),
    .num2(num2),
    .result(result),
    .flags(flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on 64-bit values
  task automatic model(input logic rst, input logic [4:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0] us;
    longint      sa, sb, ss;
    int          sh;
    logic [31:0] r;
    if (!rst) begin
      m_result = 0;
      m_flags  = 0;
      return;
    end
    sa = $signed(a);
    sb = $signed(b);
    case (ins)
      5'd1: begin
        r = a & b;
        m_flags = {m_flags[3], 1'b0, r == 0, r[31]};
      end
      5'd5, 5'd6: begin
        logic cin;
        cin = (ins == 5'd5) ? m_flags[2] : 1'b0;
        us  = {32'h0, a} + {32'h0, b} + {63'h0, cin};
        ss  = sa + sb + longint'(cin);
        r   = us[31:0];
        m_flags = {(ss > 64'sd2147483647) || (ss < -64'sd2147483648), us[32], r == 0, r[31]};
      end
      5'd12: begin
        longint q;
        sh = int'(b % 32);
        q  = sa / (64'sd1 <<< sh);
        if ((sa < 0) && (q * (64'sd1 <<< sh) != sa)) q = q - 1;  // floor division
        r  = q[31:0];
        m_flags[0] = r[31];
        m_flags[1] = (r == 0);
        if (sh != 0) m_flags[2] = a[sh-1];
      end
      default: r = 0;
    endcase
    m_result = r;
  endtask

  // Apply one operation, clock it, and compare against the model
  task automatic step(input logic rst, input logic [4:0] ins,
                      input logic [31:0] a, input logic [31:0] b, input string tag);
    rst_n = rst; instruction = ins; num1 = a; num2 = b;
    @(posedge clk);
    #1;
    model(rst, ins, a, b);
    check({tag, ".result"}, result, m_result);
    check({tag, ".flags"}, {28'h0, flags}, {28'h0, m_flags});
  endtask

  initial begin
    logic [4:0]  ins;
    logic [31:0] a, b;
    logic        rst;
    m_result = 0; m_flags = 0;
    rst_n = 1'b0; instruction = 5'd6; num1 = 0; num2 = 0;
    @(negedge clk);

    step(1'b0, 5'd6, 32'd5, 32'd7, "reset");
    check("reset_const", result, 32'h0);
    step(1'b1, 5'd6, 32'd5, 32'd7, "add_after_reset");
    check("add_12", result, 32'd12);

    step(1'b1, 5'd1, 32'hF0F0_0000, 32'hFF00_0000, "and_n");
    check("and_const", {28'h0, flags[2:0]}, 32'h1);
    step(1'b1, 5'd1, 32'hF0F0_0000, 32'h0, "and_z");

    step(1'b1, 5'd6, 32'hFFFF_FFFF, 32'd1, "adds_carry");
    check("adds_carry_c", {31'h0, flags[2]}, 32'h1);
    step(1'b1, 5'd5, 32'd5, 32'd7, "adcs");
    check("adcs_13", result, 32'd13);

    step(1'b1, 5'd6, 32'h7FFF_FFFF, 32'd1, "ovf_pos");
    check("ovf_pos_v", {31'h0, flags[3]}, 32'h1);
    step(1'b1, 5'd6, 32'h8000_0000, 32'h8000_0000, "ovf_neg");

    step(1'b1, 5'd12, 32'h8000_0018, 32'd4, "asr4");
    check("asr4_const", result, 32'hF800_0001);
    step(1'b1, 5'd12, 32'h8000_0018, 32'd31, "asr31_neg");
    step(1'b1, 5'd12, 32'h4000_0000, 32'd31, "asr31_pos");

    step(1'b1, 5'd6, 32'h8000_0000, 32'h8000_0000, "set_c");
    step(1'b1, 5'd12, 32'h1234_5678, 32'h20, "asr0");
    check("asr0_c", {31'h0, flags[2]}, 32'h1);
    step(1'b1, 5'd18, 32'h1234_5678, 32'h9, "unused18");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: ins = 5'd1;
        1: ins = 5'd5;
        2: ins = 5'd6;
        3, 4: ins = 5'd12;
        default: ins = 5'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
      rst = ($urandom_range(0, 49) != 0);
      step(rst, ins, a, b, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
